// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- LC-3b memory-access pipeline stage
//
// Takes the instruction leaving execute, runs the data-memory handshake for
// LDR/STR/LDB/STB, the two-access LDI/STI and the TRAP vector fetch, and
// registers the MEM/WB fields consumed by writeback. stall_out freezes the
// upstream stages while an access is outstanding.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ex_*              instruction leaving execute (valid, ir, alu_out,
//                     store_data, pc)
//   flush             squash the instruction held in this stage
//   stall_out         freeze IF/ID/EX
//   dmem_*            data-memory request/response handshake
//   wb_*              MEM/WB pipeline register
//
// Optional feature (macro MEM_STAGE_PERF_EN):
//   perf_stall_cycles counts cycles with stall_out=1,
//   perf_mem_ops      counts accepted dmem_resp pulses.
//   Both saturate at 16'hFFFF and clear on reset.
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [15:0] ex_ir,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_store_data,
    input  logic [15:0] ex_pc,
    input  logic        flush,
    output logic        stall_out,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        wb_valid,
    output logic [15:0] wb_ir,
    output logic [15:0] wb_alu_out,
    output logic [15:0] wb_mem_data,
    output logic [15:0] wb_pc
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [15:0] perf_stall_cycles,
    output logic [15:0] perf_mem_ops
`endif
);

    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        squash_q, squash_d;
    logic [15:0] ir_q, addr_q, sdata_q, pc_q;
    logic [15:1] ptr_q;
    logic        wb_valid_q;
    logic [15:0] wb_ir_q, wb_alu_q, wb_mem_q, wb_pc_q;

    logic [3:0]  op_q;
    logic        ex_is_mem;
    logic        two_access;
    logic        squash_now;
    logic        start;
    logic        advance;
    logic        finish;
    logic [15:0] load_data;

    assign op_q       = ir_q[15:12];
    assign ex_is_mem  = (ex_ir[15:12] inside {OP_LDB, OP_STB, OP_LDR, OP_STR,
                                              OP_LDI, OP_STI, OP_TRAP});
    assign two_access = (op_q == OP_LDI) || (op_q == OP_STI);
    // A flush arriving in the response cycle counts as well as an earlier one.
    assign squash_now = squash_q | flush;

    assign start   = (state_q == S_IDLE) && ex_valid && ex_is_mem && !flush;
    // The pointer access of LDI/STI moves on to ACC2 unless squashed, in which
    // case the second access is skipped entirely.
    assign advance = dmem_resp && (state_q == S_ACC1) && two_access && !squash_now;
    assign finish  = dmem_resp && (state_q != S_IDLE) && !advance;

    assign stall_out = start || ((state_q != S_IDLE) && !finish);

    // Request signals depend only on registered state, so they stay steady
    // until the response and drop as soon as reset forces IDLE.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        dmem_address = '0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_wmask   = 2'b00;
        dmem_wdata   = '0;
        case (state_q)
            S_ACC1: begin
                dmem_address = {addr_q[15:1], 1'b0};
                if (op_q == OP_STR) begin
                    dmem_write = 1'b1;
                    dmem_wmask = 2'b11;
                    dmem_wdata = sdata_q;
                end else if (op_q == OP_STB) begin
                    dmem_write = 1'b1;
                    dmem_wmask = addr_q[0] ? 2'b10 : 2'b01;
                    dmem_wdata = {sdata_q[7:0], sdata_q[7:0]};
                end else begin
                    dmem_read = 1'b1;
                end
            end
            S_ACC2: begin
                dmem_address = {ptr_q, 1'b0};
                if (op_q == OP_STI) begin
                    dmem_write = 1'b1;
                    dmem_wmask = 2'b11;
                    dmem_wdata = sdata_q;
                end else begin
                    dmem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Byte loads pick the lane selected by the low address bit (1 = high).
    always_comb begin
        load_data = '0;
        case (op_q)
            OP_LDR, OP_LDI, OP_TRAP: load_data = dmem_rdata;
            OP_LDB: load_data = addr_q[0] ? {8'h00, dmem_rdata[15:8]}
                                          : {8'h00, dmem_rdata[7:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        case (state_q)
            S_IDLE: begin
                squash_d = 1'b0;
                if (start) state_d = S_ACC1;
            end
            S_ACC1, S_ACC2: begin
                if (advance) begin
                    state_d = S_ACC2;
                end else if (finish) begin
                    state_d  = S_IDLE;
                    squash_d = 1'b0;
                end else begin
                    squash_d = squash_now;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            squash_q   <= 1'b0;
            ir_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            pc_q       <= '0;
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_ir_q    <= '0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_pc_q    <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            if (state_q == S_IDLE) begin
                if (start) begin
                    ir_q       <= ex_ir;
                    addr_q     <= ex_alu_out;
                    sdata_q    <= ex_store_data;
                    pc_q       <= ex_pc;
                    wb_valid_q <= 1'b0;  // bubble while the access runs
                end else begin
                    wb_valid_q <= ex_valid & ~flush;
                    wb_ir_q    <= ex_ir;
                    wb_alu_q   <= ex_alu_out;
                    wb_mem_q   <= '0;
                    wb_pc_q    <= ex_pc;
                end
            end else if (advance) begin
                ptr_q      <= dmem_rdata[15:1];
                wb_valid_q <= 1'b0;
            end else if (finish) begin
                wb_valid_q <= ~squash_now;
                wb_ir_q    <= ir_q;
                wb_alu_q   <= addr_q;
                wb_mem_q   <= load_data;
                wb_pc_q    <= pc_q;
            end else begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_ir       = wb_ir_q;
    assign wb_alu_out  = wb_alu_q;
    assign wb_mem_data = wb_mem_q;
    assign wb_pc       = wb_pc_q;

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] perf_stall_q, perf_ops_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_ops_q   <= '0;
        end else begin
            if (stall_out && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
            if (dmem_resp && state_q != S_IDLE && perf_ops_q != 16'hFFFF)
                perf_ops_q <= perf_ops_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_mem_ops      = perf_ops_q;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the LC-3b pipeline.
- Takes the instruction leaving execute, performs data-memory reads and writes through a multi-cycle handshake, and registers the MEM/WB fields consumed by writeback.
- Covers LDR/STR/LDB/STB, two-access LDI/STI, and the TRAP vector fetch.
- Asserts a stall to upstream stages while an access is outstanding.

Parameters:
- none (16-bit datapath fixed by lc3b_types)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage holds a real instruction
- ex_ir  in  16  instruction word
- ex_alu_out  in  16  effective address or ALU result
- ex_store_data  in  16  SR value for stores
- ex_pc  in  16  PC+2 of the instruction
- flush  in  1  squash the instruction in this stage (from writeback branch resolution)
- stall_out  out  1  freeze IF/ID/EX
- dmem_address  out  16  data memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  2  byte enables
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data
- dmem_resp  in  1  access complete
- wb_valid  out  1  MEM/WB register holds a real instruction
- wb_ir  out  16  registered ex_ir
- wb_alu_out  out  16  registered ex_alu_out
- wb_mem_data  out  16  registered load data, byte-adjusted
- wb_pc  out  16  registered ex_pc

Behaviour:
- Memory opcodes: LDR 0110, STR 0111, LDB 0010, STB 0011, LDI 1010, STI 1011, TRAP 1111. All other opcodes are pass-through.
- Reset: state IDLE, squash flag 0, all outputs 0, dmem_read and dmem_write drop immediately.
- FSM states: IDLE, ACC1, ACC2.
- IDLE, pass-through (ex_valid=0 or non-memory op):
  - MEM/WB loads at the next edge; latency 1.
  - wb_valid = ex_valid & ~flush; wb_mem_data = 0.
- IDLE, memory op with ex_valid=1 and flush=0:
  - Latch ir, alu_out, store_data, pc; go to ACC1.
  - stall_out=1 combinationally this cycle.
  - wb_valid=0 at the next edge (bubble).
- ACC1:
  - Drive the address and assert read (LDR/LDB/LDI/STI/TRAP) or write (STR/STB). Hold all request signals steady until dmem_resp.
  - On resp with LDI/STI: latch dmem_rdata as the pointer and go to ACC2.
  - On resp otherwise: load MEM/WB with wb_valid = ~squash and go to IDLE.
  - stall_out=1 in every cycle except the resp cycle that returns to IDLE.
- ACC2:
  - LDI reads at the pointer; STI writes store_data at the pointer.
  - On resp: load MEM/WB and go to IDLE. stall_out as in ACC1.
- Word ops: dmem_address = {addr[15:1],0}; wmask = 11.
- LDB: wb_mem_data = ZEXT of byte addr[0] (1 = high byte).
- STB: wdata = {sr[7:0],sr[7:0]}; wmask = addr[0] ? 10 : 01.
- TRAP: word read at alu_out; wb_mem_data = vector.
- While stalled (state≠IDLE and no resp), the MEM/WB register holds with wb_valid=0.
- flush during ACC1/ACC2:
  - The transaction is never aborted; requests are held until resp.
  - Sets the squash flag, so the result is dropped (wb_valid=0) and the STI second access is skipped.
  - A STR/STB already requested completes its write.
- flush and a memory-op arrival in the same IDLE cycle: no access is started.
- dmem_resp while IDLE is ignored.
- Reset asserted mid-access: FSM returns to IDLE asynchronously and the pending instruction is lost.

Optional Feature:
- Macro MEM_STAGE_PERF_EN.
- Defined: adds outputs perf_stall_cycles[15:0] (increments each cycle stall_out=1) and perf_mem_ops[15:0] (increments on each dmem_resp accepted). Both saturate at FFFF and clear on reset.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- LDR, alu_out=3006, rdata=BEEF, resp after 3 cycles -> address 3006, read held 3 cycles, stall 3 cycles; next edge wb_valid=1, wb_mem_data=BEEF.
- STB, alu_out=4001, sr=00A5, resp after 1 cycle -> wmask=10, wdata=A5A5, write=1; wb_valid=1 after resp.
- LDI, alu_out=2000; mem[2000]=2100, mem[2100]=1234 -> two reads, second at 2100; wb_mem_data=1234; stall covers both accesses.
- LDB, alu_out=5003, rdata=80FF -> wb_mem_data=0080.
- flush asserted in ACC1 of STI, first resp at cycle 2 -> no second access; wb_valid=0; stall drops after resp.
- ADD passes with ex_valid=1 and flush=0 -> wb_valid=1 one cycle later, no dmem request. Reset asserted during an LDR access -> dmem_read falls without a clock edge.
